// File: rtl/mem_bus_arbiter.sv
// Purpose: arbitrates the icache and dcache controllers onto the single memory port and routes returning tags to their owner.
// Latency: zero-cycle grant and response/tag routing; ownership and starvation state update on the clock edge.
// Backpressure: there is no queueing here; a rejected grant (response 0) is simply retried by the requester on a later cycle.
//
// Ports:
//   clock, reset                         - system clock, synchronous active-high reset
//   icache2arb_addr/command              - icache request (LOAD or NONE)
//   dcache2arb_addr/command/data         - dcache request (LOAD, STORE or NONE) plus store data
//   mem2arb_response                     - memory accept tag for the granted request, 0 = rejected/none
//   mem2arb_tag/data                     - returning load tag (0 = none) and its data
//   arb2mem_addr/command/data            - the granted request
//   arb2icache_response/tag/data         - accept tag, owned returned tag and data passthrough for icache
//   arb2dcache_response/tag/data         - accept tag, owned returned tag and data passthrough for dcache
//   arb_outstanding                      - number of tags currently owned by either side
//   arb_orphan_tag                       - a nonzero tag returned that nobody owns
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [63:0] icache2arb_addr,
    input  logic [1:0]  icache2arb_command,

    input  logic [63:0] dcache2arb_addr,
    input  logic [1:0]  dcache2arb_command,
    input  logic [63:0] dcache2arb_data,

    input  logic [3:0]  mem2arb_response,
    input  logic [3:0]  mem2arb_tag,
    input  logic [63:0] mem2arb_data,

    output logic [63:0] arb2mem_addr,
    output logic [1:0]  arb2mem_command,
    output logic [63:0] arb2mem_data,

    output logic [3:0]  arb2icache_response,
    output logic [3:0]  arb2icache_tag,
    output logic [63:0] arb2icache_data,

    output logic [3:0]  arb2dcache_response,
    output logic [3:0]  arb2dcache_tag,
    output logic [63:0] arb2dcache_data,

    output logic [4:0]  arb_outstanding,
    output logic        arb_orphan_tag
);

    // Bus command encoding shared with both cache controllers: 0 none, 1 load, 2 store.
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    // Ownership table indexed by memory tag. Entry 0 means "no tag" and is
    // held at zero so it can never look owned.
    logic [15:0] own_valid;
    logic [15:0] own_is_dcache;
    logic [15:0] own_valid_nxt;
    logic [15:0] own_is_dcache_nxt;

    // Consecutive accepted dcache transactions while icache was waiting.
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_cnt_nxt;

    logic        icache_req;
    logic        dcache_req;
    logic        starve_hit;
    logic        grant_icache;
    logic        grant_dcache;
    logic [1:0]  granted_cmd;
    logic        accepted;
    logic        alloc;
    logic        tag_nonzero;
    logic        tag_hit;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    assign icache_req  = (icache2arb_command != BUS_NONE);
    assign dcache_req  = (dcache2arb_command != BUS_NONE);

    // Once icache has watched STARVE_LIMIT dcache transactions go by, it
    // wins the next cycle regardless of dcache.
    assign starve_hit   = icache_req && (starve_cnt == STARVE_LIM);
    assign grant_dcache = !reset && dcache_req && !starve_hit;
    assign grant_icache = !reset && icache_req && !grant_dcache;

    always_comb begin
        granted_cmd  = BUS_NONE;
        arb2mem_addr = 64'd0;
        arb2mem_data = 64'd0;
        if (grant_dcache) begin
            granted_cmd  = dcache2arb_command;
            arb2mem_addr = dcache2arb_addr;
            arb2mem_data = dcache2arb_data;
        end else if (grant_icache) begin
            granted_cmd  = icache2arb_command;
            arb2mem_addr = icache2arb_addr;
        end
    end

    assign arb2mem_command = granted_cmd;

    assign accepted = (grant_dcache || grant_icache) && (mem2arb_response != 4'd0);
    // Stores complete on accept and never come back with a tag.
    assign alloc    = accepted && (granted_cmd == BUS_LOAD);

    // ------------------------------------------------------------------
    // Accept routing: only the granted side ever sees a nonzero response.
    // ------------------------------------------------------------------
    assign arb2icache_response = grant_icache ? mem2arb_response : 4'd0;
    assign arb2dcache_response = grant_dcache ? mem2arb_response : 4'd0;

    // ------------------------------------------------------------------
    // Tag return routing, looked up against the registered table so a
    // same-cycle reallocation does not steal the returning tag.
    // ------------------------------------------------------------------
    assign tag_nonzero = !reset && (mem2arb_tag != 4'd0);
    assign tag_hit     = tag_nonzero && own_valid[mem2arb_tag];

    assign arb2icache_tag = (tag_hit && !own_is_dcache[mem2arb_tag]) ? mem2arb_tag : 4'd0;
    assign arb2dcache_tag = (tag_hit &&  own_is_dcache[mem2arb_tag]) ? mem2arb_tag : 4'd0;
    assign arb_orphan_tag = tag_nonzero && !own_valid[mem2arb_tag];

    // Consumers qualify data with their tag output, so no muxing is needed.
    assign arb2icache_data = mem2arb_data;
    assign arb2dcache_data = mem2arb_data;

    // ------------------------------------------------------------------
    // Next-state: ownership. Clear before set so a tag returned and
    // reissued in the same cycle ends up owned by the new requester.
    // ------------------------------------------------------------------
    always_comb begin
        own_valid_nxt     = own_valid;
        own_is_dcache_nxt = own_is_dcache;
        if (tag_hit) begin
            own_valid_nxt[mem2arb_tag] = 1'b0;
        end
        if (alloc) begin
            own_valid_nxt[mem2arb_response]     = 1'b1;
            own_is_dcache_nxt[mem2arb_response] = grant_dcache;
        end
        own_valid_nxt[0]     = 1'b0;
        own_is_dcache_nxt[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Next-state: starvation counter. A rejected grant leaves the count
    // alone so retries do not count against icache.
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!icache_req) begin
            starve_cnt_nxt = 4'd0;
        end else if (!accepted) begin
            starve_cnt_nxt = starve_cnt;
        end else if (grant_icache) begin
            starve_cnt_nxt = 4'd0;
        end else if (grant_dcache && (starve_cnt < STARVE_LIM)) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            own_valid     <= 16'd0;
            own_is_dcache <= 16'd0;
            starve_cnt    <= 4'd0;
        end else begin
            own_valid     <= own_valid_nxt;
            own_is_dcache <= own_is_dcache_nxt;
            starve_cnt    <= starve_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding count: population count of the ownership table.
    // ------------------------------------------------------------------
    always_comb begin
        arb_outstanding = 5'd0;
        for (int i = 1; i < 16; i++) begin
            arb_outstanding = arb_outstanding + 5'(own_valid[i]);
        end
    end

endmodule
